rv_transmitter: RTL and testbench
=================================

RV_TRANSMITTER -- requirements
Module: rv_transmitter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of each transferred word.
REQ-002 SHALL have parameter DEPTH, default 4, number of buffered words; a power of two, at least 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port load  input  1  producer request to enqueue data_in this cycle.
REQ-006 SHALL have port data_in  input  DATA_WIDTH  word to enqueue.
REQ-007 SHALL have port load_ready  output  1  high when a load is accepted this cycle (buffer not full).
REQ-008 SHALL have port valid  output  1  downstream handshake: data_out holds a valid word.
REQ-009 SHALL have port ready  input  1  downstream handshake: consumer accepts data_out this cycle.
REQ-010 SHALL have port data_out  output  DATA_WIDTH  word presented downstream (head of buffer).
REQ-011 SHALL have port en_data_Tx  output  1  combinational transfer strobe, valid && ready.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  number of words currently buffered.
REQ-013 SHALL have port tx_total  output  16  number of completed transfers since reset, wraps modulo 2^16.

Function
REQ-014 SHALL implement a circular buffer of DEPTH entries with a write pointer, a read pointer and an occupancy counter.
REQ-015 SHALL implement a two-state FSM:
- IDLE: buffer empty, valid=0.
- SEND: buffer non-empty, valid=1.
REQ-016 SHALL drive valid=1 exactly in SEND; valid is registered, never combinational from ready.
REQ-017 SHALL accept a load only when load && load_ready, writing data_in at the write pointer and incrementing the write pointer modulo DEPTH.
REQ-018 SHALL drive load_ready = (count < DEPTH) combinationally from registered count, independent of ready.
REQ-019 SHALL complete a transfer only when valid && ready, advancing the read pointer modulo DEPTH and incrementing tx_total.
REQ-020 SHALL hold data_out and valid stable while valid && !ready; the read pointer never moves without a transfer.
REQ-021 SHALL drive data_out from the entry at the read pointer.
- data_out SHALL be 0 when count is 0.
REQ-022 SHALL have load-to-valid latency of one cycle: a word loaded into an empty buffer appears with valid=1 on the next cycle.
REQ-023 SHALL update count on a simultaneous accepted load and transfer as follows:
- count unchanged.
- both pointers advance.
- order preserved.
REQ-024 SHALL ignore a load when full (load_ready=0) even if a transfer occurs in the same cycle; there is no full-buffer pass-through.
REQ-025 SHALL have the following FSM transitions:
- IDLE->SEND on an accepted load.
- SEND->IDLE when count=1, a transfer occurs and no load is accepted.
- Otherwise SEND remains SEND.
REQ-026 SHALL deliver words downstream in exactly the order accepted, with no loss or duplication.
REQ-027 SHALL wrap pointers and tx_total silently with no error indication.
REQ-028 SHALL have en_data_Tx high for exactly one cycle per transferred word.

Reset
REQ-029 SHALL, while reset=0, asynchronously force:
- state=IDLE, valid=0, data_out=0, count=0, tx_total=0.
- both pointers to 0.
- load_ready=1.
REQ-030 SHALL discard buffered words on reset asserted mid-operation; the block resumes in IDLE after reset returns to 1.
REQ-031 SHALL leave buffer storage contents unreset; storage is unobservable while count=0.

Verification
REQ-032 SHALL cover single word: load 0xDEAD_BEEF_0000_0001 into empty buffer, ready=1 -> valid=1 and data_out=0xDEAD_BEEF_0000_0001 next cycle, en_data_Tx pulses once, count returns to 0, tx_total=1.
REQ-033 SHALL cover backpressure: load 3 words with ready=0 for 5 cycles -> valid=1, data_out stays word 0, count=3; then ready=1 -> words 0,1,2 out on 3 consecutive cycles.
REQ-034 SHALL cover full: 4 loads with ready=0 -> count=4, load_ready=0; a 5th load with ready=1 in the same cycle is dropped, count=3 next cycle, and word 0 is transferred.
REQ-035 SHALL cover simultaneous: count=2, load and transfer in the same cycle -> count stays 2, output order matches input order across the pointer wrap.
REQ-036 SHALL cover reset mid-operation: count=3, reset=0 asynchronously -> valid=0, count=0, data_out=0 immediately; after release, a new load is the next word out.
REQ-037 SHALL cover streaming: 70000 words with load=1 and ready=1 continuously -> a transfer every cycle after the first, tx_total wraps to 70000 mod 65536 = 4464.

Source files
------------

// File: rtl/rv_transmitter.sv
// Buffered ready/valid transmitter: a DEPTH-entry circular buffer that feeds a
// downstream ready/valid link, with a registered valid and a transfer counter.
module rv_transmitter #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic                       load_ready,
    output logic                       valid,
    input  logic                       ready,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       en_data_Tx,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                tx_total
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state, state_next;
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        count_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    load_acc;
    logic                    xfer;

    assign load_ready = (count < FULL_CNT);
    assign load_acc   = load && load_ready;
    assign valid      = (state == SEND);
    assign xfer       = valid && ready;
    assign en_data_Tx = xfer;
    // Head of buffer; forced to zero when empty so reset and idle read as 0.
    assign data_out   = (count == '0) ? '0 : mem[rd_ptr];

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: if (load_acc) state_next = SEND;
            SEND: if (xfer && !load_acc && count == ONE_CNT) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        case ({load_acc, xfer})
            2'b10:   count_next = count + ONE_CNT;
            2'b01:   count_next = count - ONE_CNT;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_total <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (load_acc) wr_ptr <= wr_ptr + 1'b1;
            if (xfer) begin
                rd_ptr   <= rd_ptr + 1'b1;
                tx_total <= tx_total + 16'd1;
            end
        end
    end

    // Storage is not reset; it is unobservable while the buffer is empty.
    always_ff @(posedge clk) begin
        if (load_acc) mem[wr_ptr] <= data_in;
    end

endmodule

// File: tb/tb_rv_transmitter.sv
// Self-checking bench for rv_transmitter: queue-based reference model compared
// every cycle, plus literal expectations for the directed scenarios.
module tb_rv_transmitter;

    localparam int DATA_WIDTH = 64;
    localparam int DEPTH      = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  load;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  load_ready;
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  en_data_Tx;
    logic [$clog2(DEPTH):0] count;
    logic [15:0]           tx_total;

    int checks   = 0;
    int failures = 0;

    logic [DATA_WIDTH-1:0] q[$];
    logic [15:0]           tx_m;

    rv_transmitter #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .load(load), .data_in(data_in),
        .load_ready(load_ready), .valid(valid), .ready(ready),
        .data_out(data_out), .en_data_Tx(en_data_Tx), .count(count),
        .tx_total(tx_total)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs derived from the queue contents and the current inputs.
    task automatic compare_model();
        logic          e_valid;
        logic [63:0]   e_data;
        e_valid = (q.size() > 0);
        e_data  = e_valid ? q[0] : 64'd0;
        chk("valid",      64'(valid),      64'(e_valid));
        chk("data_out",   data_out,        e_data);
        chk("count",      64'(count),      64'(q.size()));
        chk("load_ready", 64'(load_ready), 64'(q.size() < DEPTH));
        chk("en_data_Tx", 64'(en_data_Tx), 64'(e_valid && ready));
        chk("tx_total",   64'(tx_total),   64'(tx_m));
    endtask

    // Called at a negedge: drive inputs, then compare just after.
    task automatic cyc(input logic l, input logic [63:0] d, input logic r);
        load    = l;
        data_in = d;
        ready   = r;
        #1;
        compare_model();
    endtask

    // Apply the clock edge to the model and DUT, return at the next negedge.
    task automatic adv();
        logic acc, xf;
        if (reset) begin
            acc = load && (q.size() < DEPTH);
            xf  = (q.size() > 0) && ready;
            if (xf) begin
                void'(q.pop_front());
                tx_m = tx_m + 16'd1;
            end
            if (acc) q.push_back(data_in);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic l, input logic [63:0] d, input logic r);
        cyc(l, d, r);
        adv();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 64'd0, 1'b1);
    endtask

    initial begin
        logic [63:0] w [8];
        reset   = 1'b0;
        load    = 1'b0;
        ready   = 1'b0;
        data_in = '0;
        tx_m    = '0;
        for (int i = 0; i < 8; i++) w[i] = 64'hA000_0000_0000_0000 + 64'(i);

        // Reset state
        @(negedge clk);
        cyc(1'b1, 64'h1234, 1'b1);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_load_ready", 64'(load_ready), 64'd1);
        chk("rst_data_out", data_out, 64'd0);
        chk("rst_tx_total", 64'(tx_total), 64'd0);
        adv();
        reset = 1'b1;

        // Single word
        step(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1);
        cyc(1'b0, 64'd0, 1'b1);
        chk("single_valid", 64'(valid), 64'd1);
        chk("single_data", data_out, 64'hDEAD_BEEF_0000_0001);
        chk("single_en", 64'(en_data_Tx), 64'd1);
        adv();
        cyc(1'b0, 64'd0, 1'b1);
        chk("single_count", 64'(count), 64'd0);
        chk("single_en_once", 64'(en_data_Tx), 64'd0);
        chk("single_tx_total", 64'(tx_total), 64'd1);
        adv();

        // Backpressure
        for (int i = 0; i < 3; i++) step(1'b1, w[i], 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 64'd0, 1'b0);
            chk("bp_hold_data", data_out, w[0]);
            chk("bp_hold_count", 64'(count), 64'd3);
            adv();
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 64'd0, 1'b1);
            chk("bp_out_en", 64'(en_data_Tx), 64'd1);
            chk("bp_out_data", data_out, w[i]);
            adv();
        end
        drain();

        // Full buffer, dropped load during transfer
        for (int i = 0; i < 4; i++) step(1'b1, w[i], 1'b0);
        cyc(1'b1, w[4], 1'b1);
        chk("full_count", 64'(count), 64'd4);
        chk("full_load_ready", 64'(load_ready), 64'd0);
        chk("full_xfer_data", data_out, w[0]);
        adv();
        cyc(1'b0, 64'd0, 1'b0);
        chk("full_after_count", 64'(count), 64'd3);
        chk("full_after_head", data_out, w[1]);
        adv();
        drain();

        // Simultaneous load and transfer across pointer wrap
        step(1'b1, w[0], 1'b0);
        step(1'b1, w[1], 1'b0);
        for (int i = 2; i < 8; i++) begin
            cyc(1'b1, w[i], 1'b1);
            chk("simul_count", 64'(count), 64'd2);
            chk("simul_order", data_out, w[i-2]);
            adv();
        end
        drain();

        // Randomized traffic
        for (int i = 0; i < 2000; i++)
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
        drain();

        // Reset mid-operation
        for (int i = 0; i < 3; i++) step(1'b1, w[i], 1'b0);
        cyc(1'b0, 64'd0, 1'b0);
        #1 reset = 1'b0;
        #1;
        chk("midrst_valid", 64'(valid), 64'd0);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_data_out", data_out, 64'd0);
        chk("midrst_load_ready", 64'(load_ready), 64'd1);
        q.delete();
        tx_m = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 64'h0BAD_CAFE_0000_0077, 1'b0);
        cyc(1'b0, 64'd0, 1'b1);
        chk("postrst_first", data_out, 64'h0BAD_CAFE_0000_0077);
        chk("postrst_count", 64'(count), 64'd1);
        adv();
        drain();

        // Streaming with tx_total wrap
        q.delete();
        tx_m = tx_total;
        chk("stream_start_tx", 64'(tx_total), 64'd1);
        for (int i = 0; i < 70000; i++) step(1'b1, 64'(i), 1'b1);
        step(1'b0, 64'd0, 1'b1);
        cyc(1'b0, 64'd0, 1'b1);
        chk("stream_tx_wrap", 64'(tx_total), 64'(16'(1 + 70000)));
        chk("stream_tx_wrap_lit", 64'(tx_total - 16'd1), 64'd4464);
        chk("stream_empty", 64'(count), 64'd0);
        adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
